inv_subbytes_seq: RTL and testbench
===================================

Name: inv_subbytes_seq

Overview:
- Sequencer that applies inverse SubBytes to a 128-bit AES state by time-multiplexing NUM_SBOX instances of the team's existing combinational inverse S-box.
- Sits in the decryption round datapath between the inverse ShiftRows and AddRoundKey stages.
- Trades area for latency: 16/NUM_SBOX substitution cycles per state.
- Valid/ready handshake on both sides.

Parameters:
- NUM_SBOX, 4, number of parallel inverse S-box lanes. Legal values are 1, 2, 4, 8 and 16; any other value is a compile-time error.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream has a state on in_state.
- in_ready  output  1  block can accept a new state.
- in_state  input  128  input state; byte i = in_state[127-8i -: 8], i = 0..15.
- out_valid  output  1  out_state holds a completed result.
- out_ready  input  1  downstream accepts the result.
- out_state  output  128  substituted state, same byte ordering as in_state.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Parameter-derived constants:
  - STEPS = 16/NUM_SBOX.
  - Step counter width = max(1, clog2(STEPS)).
- Internal 128-bit working register wreg drives out_state directly.
- Reset (async, rst=1):
  - FSM=IDLE, counter=0, wreg=0.
  - in_ready=1, out_valid=0, busy=0, out_state=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: wreg<=in_state, counter<=0, go to RUN.
- RUN:
  - in_ready=0.
  - Each edge replaces bytes [counter*NUM_SBOX .. counter*NUM_SBOX+NUM_SBOX-1] of wreg with their inverse S-box values; lane k handles byte counter*NUM_SBOX+k.
  - Counter increments each edge.
  - On the edge where counter==STEPS-1, go to DONE and clear the counter to 0.
  - in_valid is ignored.
- DONE:
  - out_valid=1, wreg held stable.
  - On an edge with out_ready=1, go to IDLE.
  - No new input is accepted in the same cycle; in_ready rises one cycle later.
- Latency:
  - The accept edge is A.
  - out_valid rises immediately after edge A+STEPS.
  - NUM_SBOX=4: 4 edges after accept. NUM_SBOX=16: 1 edge. NUM_SBOX=1: 16 edges.
- Throughput: one state per STEPS+2 cycles, with out_ready held high.
- Downstream backpressure: out_valid and out_state must stay stable while out_ready=0, indefinitely.
- out_state is not guaranteed meaningful while out_valid=0; in RUN it shows partially substituted bytes.
- Unprocessed bytes are never modified before their step.
- Bytes are processed exactly once; there is no double substitution.
- Reset mid-operation (RUN or DONE): asynchronously return to the reset values. The partial result is discarded and no out_valid pulse is produced.
- out_ready=1 while not in DONE has no effect.

Test Plan:
- Reset then basic substitution:
  - Stimulus: NUM_SBOX=4, in_state=000102030405060708090a0b0c0d0e0f, in_valid pulse.
  - Required: out_valid rises 4 edges after accept; out_state=52096ad53036a538bf40a39e81f3d7fb.
- Latency sweep:
  - Stimulus: same vector with NUM_SBOX = 1, 2, 8 and 16.
  - Required: out_valid after 16, 8, 2 and 1 edges respectively; identical out_state.
- Backpressure:
  - Stimulus: hold out_ready=0 for 10 cycles in DONE while toggling in_valid and in_state.
  - Required: out_valid=1, out_state unchanged, in_ready=0 throughout.
  - Then out_ready=1 for one edge: out_valid=0 and in_ready=1 on the next cycle.
- Back-to-back operation:
  - Stimulus: in_valid and out_ready held high, inputs 00..00 then 10101010...10.
  - Required: outputs 5252...52 then 7c7c...7c.
  - Accepts spaced STEPS+2 cycles apart, no input dropped.
- Reset mid-RUN:
  - Stimulus: assert rst for 1 cycle at step 2 (NUM_SBOX=4).
  - Required: immediate out_valid=0, busy=0, in_ready=1, out_state=0.
  - A subsequent new input produces a correct result.
- Input ignored while busy:
  - Stimulus: change in_state during RUN.
  - Required: the result matches only the originally accepted state.

Source files
------------

// File: rtl/inv_subbytes_seq.sv
// Inverse SubBytes sequencer for a 128-bit AES state.
// NUM_SBOX inverse S-box lanes are time-multiplexed over the 16 bytes.
module inv_subbytes_seq #(
  parameter int NUM_SBOX = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int STEPS = 16 / NUM_SBOX;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  if (NUM_SBOX != 1 && NUM_SBOX != 2 && NUM_SBOX != 4 &&
      NUM_SBOX != 8 && NUM_SBOX != 16) begin : g_bad_num_sbox
    $error("NUM_SBOX must be 1, 2, 4, 8 or 16");
  end

  // Inverse S-box table, entry 0 in the most significant byte.
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[2047 - 8 * int'(b) -: 8];
  endfunction

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [127:0]    wreg;
  logic [127:0]    sub_next;
  int              pos;

  assign out_state = wreg;

  // Substitute only the bytes owned by the current step.
  always_comb begin
    sub_next = wreg;
    pos      = 0;
    for (int k = 0; k < NUM_SBOX; k++) begin
      pos = int'(cnt) * NUM_SBOX + k;
      sub_next[127 - 8 * pos -: 8] = inv_sbox(wreg[127 - 8 * pos -: 8]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      wreg      <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            wreg     <= in_state;
            cnt      <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          wreg <= sub_next;
          if (cnt == CW'(STEPS - 1)) begin
            cnt       <= '0;
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          cnt       <= '0;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inv_subbytes_seq.sv
// Scoreboard bench for inv_subbytes_seq; five instances cover every lane count.
module tb_inv_subbytes_seq;

  localparam logic [127:0] V_SEQ  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] E_SEQ  = 128'h52096ad53036a538bf40a39e81f3d7fb;
  localparam logic [127:0] V_REV  = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] E_REV  = 128'hfbd7f3819ea340bf38a53630d56a0952;
  localparam logic [127:0] V_ZERO = 128'h0;
  localparam logic [127:0] E_ZERO = {16{8'h52}};
  localparam logic [127:0] V_10   = {16{8'h10}};
  localparam logic [127:0] E_10   = {16{8'h7c}};
  localparam logic [127:0] V_F0   = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  localparam logic [127:0] E_F0   = 128'h172b047eba77d626e169146355210c7d;

  localparam int MAIN = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [127:0] in_state = '0;
  logic         out_ready = 1'b0;

  logic         ir [5];
  logic         ov [5];
  logic         bz [5];
  logic [127:0] os [5];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [127:0] st;
    int           acc;
  } exp_t;

  exp_t exp_q[$];

  for (genvar g = 0; g < 5; g++) begin : g_dut
    inv_subbytes_seq #(.NUM_SBOX(1 << g)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (ir[g]),
      .in_state  (in_state),
      .out_valid (ov[g]),
      .out_ready (out_ready),
      .out_state (os[g]),
      .busy      (bz[g])
    );
  end

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Monitor: latency on rising out_valid, data on each handshake.
  logic ov_q = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      ov_q = 1'b0;
    end else begin
      if (ov[MAIN] && !ov_q) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", 128'(1), 128'(0));
        end else begin
          chk("latency", 128'(cyc - exp_q[0].acc), 128'(4));
          chk("rise_state", os[MAIN], exp_q[0].st);
        end
      end
      if (ov[MAIN] && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("handshake_empty_q", 128'(1), 128'(0));
        end else begin
          chk("out_state", os[MAIN], exp_q[0].st);
          void'(exp_q.pop_front());
        end
      end
      ov_q = ov[MAIN];
    end
  end

  // Called just after a rising edge; returns just after the accept edge.
  task automatic send(input logic [127:0] v, input logic [127:0] e,
                      input bit hold, output int acc);
    int n;
    in_state = v;
    in_valid = 1'b1;
    n = 0;
    acc = -1;
    @(negedge clk);
    while (!ir[MAIN] && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) begin
      chk("accept_timeout", 128'(1), 128'(0));
    end else begin
      @(posedge clk);
      #1;
      acc = cyc;
      exp_q.push_back('{st: e, acc: cyc});
    end
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    exp_q.delete();
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    int a1;
    int a2;
    int n;
    int lat [5];

    #23;
    for (int g = 0; g < 5; g++) begin
      chk($sformatf("rst_in_ready%0d", g), 128'(ir[g]), 128'(1));
      chk($sformatf("rst_out_valid%0d", g), 128'(ov[g]), 128'(0));
      chk($sformatf("rst_busy%0d", g), 128'(bz[g]), 128'(0));
      chk($sformatf("rst_out_state%0d", g), os[g], 128'(0));
    end
    @(posedge clk);
    #2 rst = 1'b0;

    // Basic substitution plus the lane-count latency sweep.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    for (int g = 0; g < 5; g++) lat[g] = 0;
    send(V_SEQ, E_SEQ, 0, a1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      for (int g = 0; g < 5; g++)
        if (ov[g] && lat[g] == 0) lat[g] = cyc - a1;
    end
    for (int g = 0; g < 5; g++) begin
      chk($sformatf("sweep_latency_n%0d", 1 << g), 128'(lat[g]),
          128'(16 >> g));
      chk($sformatf("sweep_state_n%0d", 1 << g), os[g], E_SEQ);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;

    // Backpressure in DONE with input noise.
    send(V_REV, E_REV, 0, a1);
    n = 0;
    while (!ov[MAIN] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_reach_done", 128'(ov[MAIN]), 128'(1));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 128'(ov[MAIN]), 128'(1));
      chk("bp_out_state", os[MAIN], E_REV);
      chk("bp_in_ready", 128'(ir[MAIN]), 128'(0));
      #1;
      in_valid = i[0];
      in_state = {4{$urandom}};
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("bp_release_out_valid", 128'(ov[MAIN]), 128'(0));
    chk("bp_release_in_ready", 128'(ir[MAIN]), 128'(1));

    // Back-to-back with both handshakes held high.
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(V_ZERO, E_ZERO, 1, a1);
    send(V_10, E_10, 0, a2);
    chk("b2b_spacing", 128'(a2 - a1), 128'(6));
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    chk("b2b_drained", 128'(exp_q.size()), 128'(0));

    // Reset two steps into RUN.
    pulse_reset();
    send(V_SEQ, E_SEQ, 0, a1);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    exp_q.delete();
    chk("midrst_out_valid", 128'(ov[MAIN]), 128'(0));
    chk("midrst_busy", 128'(bz[MAIN]), 128'(0));
    chk("midrst_in_ready", 128'(ir[MAIN]), 128'(1));
    chk("midrst_out_state", os[MAIN], 128'(0));
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    send(V_REV, E_REV, 0, a1);

    // in_state changes while RUN must not leak into the result.
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    #1;
    send(V_F0, E_F0, 0, a1);
    in_valid = 1'b1;
    in_state = V_ZERO;
    @(posedge clk);
    #1 in_state = V_10;
    @(posedge clk);
    #1 in_valid = 1'b0;

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("final_drained", 128'(exp_q.size()), 128'(0));
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
